otter_uart_tx: RTL and testbench



---
 rtl/otter_io_pkg.sv | 21 ++
 rtl/otter_sync_fifo.sv | 56 +++++
 rtl/otter_uart_tx.sv | 148 ++++++++++++++
 tb/tb_otter_uart_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/otter_io_pkg.sv
// Shared constants and types for OTTER IOBUS peripherals.
// Holds address map entries, status bit positions and the UART TX state type.
package otter_io_pkg;

    localparam logic [31:0] UART_TX_BASE       = 32'h1100_0040;
    localparam logic [31:0] UART_STATUS_OFFSET = 32'd4;

    // Bit positions inside the UART status word
    localparam int BUSY  = 0;
    localparam int FULL  = 1;
    localparam int EMPTY = 2;
    localparam int OVF   = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/otter_sync_fifo.sv
// Single-clock first-word-fall-through FIFO shared by IOBUS peripherals.
// A push into a full FIFO is accepted only when a pop retires an entry in the same cycle.
module otter_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/otter_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the OTTER IOBUS.
// Stores go through a small FIFO; a status word reports busy/full/empty/overflow.
module otter_uart_tx
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = UART_TX_BASE,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_RD_DATA,
    output logic        TX,
    output logic        TX_BUSY
);

    localparam int              BW          = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]   BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [31:0]     STATUS_ADDR = BASE_ADDR + UART_STATUS_OFFSET;

    uart_state_t   state, state_next;
    logic [BW-1:0] baud, baud_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift, shift_next;
    logic          tx_next;
    logic          overflow;

    logic          data_wr;
    logic          status_wr;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rd_data;
    logic          unused_bits;

    assign data_wr     = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR);
    assign status_wr   = IOBUS_WR && (IOBUS_ADDR == STATUS_ADDR);
    assign fifo_pop    = (state == IDLE) && !fifo_empty;
    assign TX_BUSY     = (state != IDLE) || !fifo_empty;
    assign unused_bits = ^IOBUS_OUT[31:8];

    otter_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (data_wr),
        .wr_data (IOBUS_OUT[7:0]),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_next = state;
        baud_next  = baud;
        bit_next   = bit_idx;
        shift_next = shift;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = START;
                    baud_next  = '0;
                    shift_next = fifo_rd_data;
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    state_next = DATA;
                    baud_next  = '0;
                    bit_next   = 3'd0;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud == BAUD_LAST) begin
                    state_next = IDLE;
                    baud_next  = '0;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // TX is computed from the upcoming state so the line is a clean flop output
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            TX       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
            TX      <= tx_next;
            if (data_wr && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end else if (status_wr && IOBUS_OUT[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        IOBUS_RD_DATA = 32'b0;
        if (IOBUS_ADDR == STATUS_ADDR) begin
            IOBUS_RD_DATA[BUSY]  = (state != IDLE);
            IOBUS_RD_DATA[FULL]  = fifo_full;
            IOBUS_RD_DATA[EMPTY] = fifo_empty;
            IOBUS_RD_DATA[OVF]   = overflow;
        end
    end

endmodule

// File: tb/tb_otter_uart_tx.sv
// Bench for otter_uart_tx: directed scenarios plus random bursts, with a line
// decoder and an expected-byte queue derived from the serial framing rules.
module tb_otter_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h1100_0040;
    localparam logic [31:0] STAT  = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] iobus_addr = '0;
    logic [31:0] iobus_out = '0;
    logic        iobus_wr = 1'b0;
    logic [31:0] iobus_rd_data;
    logic        tx;
    logic        tx_busy;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b1;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    otter_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .IOBUS_ADDR    (iobus_addr),
        .IOBUS_OUT     (iobus_out),
        .IOBUS_WR      (iobus_wr),
        .IOBUS_RD_DATA (iobus_rd_data),
        .TX            (tx),
        .TX_BUSY       (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        iobus_addr = addr;
        iobus_out  = data;
        iobus_wr   = 1'b1;
        @(posedge clk);
        #1;
        iobus_wr = 1'b0;
    endtask

    task automatic read_status(input string tag, input logic [31:0] expected);
        iobus_addr = STAT;
        #1;
        check(tag, iobus_rd_data, expected);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", {31'b0, tx_busy}, 32'h0);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_byte"}, {24'b0, got_q[i]}, {24'b0, exp_q[i]});
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // Line decoder: samples each bit at its midpoint once a start bit is seen
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                repeat (CPB / 2 - 1) @(negedge clk);
                check("mon_start", {31'b0, tx}, 32'h0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                check("mon_stop", {31'b0, tx}, 32'h1);
                got_q.push_back(b);
                repeat (CPB - CPB / 2) @(negedge clk);
            end
        end
    end

    // Burst of n stores in consecutive cycles starting from idle. The first byte
    // leaves the FIFO on the second store, so DEPTH+1 bytes fit before overflow.
    task automatic run_burst(input int n, input bit rand_vals, input logic [7:0] first_val);
        logic [7:0]  v;
        int          occ;
        logic [31:0] exp_st;
        bit          ovf;
        for (int i = 0; i < n; i++) begin
            v = rand_vals ? 8'($urandom_range(0, 255)) : first_val + 8'(i);
            if (i < DEPTH + 1) exp_q.push_back(v);
            bus_write(BASE, {24'($urandom), v});
        end
        occ    = (n == 1) ? 1 : ((n - 1 < DEPTH) ? n - 1 : DEPTH);
        ovf    = (n > DEPTH + 1);
        exp_st = {28'b0, ovf, 1'b0, occ == DEPTH, n >= 2};
        read_status("burst_status", exp_st);
        wait_idle();
        compare_rx("burst_rx");
        read_status("burst_idle_status", {28'b0, ovf, 3'b100});
        if (ovf) begin
            bus_write(STAT, 32'h8);
            read_status("ovf_clear", 32'h4);
        end
    endtask

    initial begin
        logic [9:0] frame;
        int         n;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset / idle
        repeat (50) @(negedge clk);
        check("idle_tx", {31'b0, tx}, 32'h1);
        check("idle_busy", {31'b0, tx_busy}, 32'h0);
        read_status("idle_status", 32'h4);

        // Exact waveform of one frame
        frame = {1'b1, 8'h55, 1'b0};
        exp_q.push_back(8'h55);
        bus_write(BASE, 32'hFFFF_FF55);
        @(negedge clk);
        check("pre_start_tx", {31'b0, tx}, 32'h1);
        check("pre_start_busy", {31'b0, tx_busy}, 32'h1);
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            check("frame_bit", {31'b0, tx}, {31'b0, frame[c / CPB]});
        end
        @(negedge clk);
        check("post_frame_tx", {31'b0, tx}, 32'h1);
        check("post_frame_busy", {31'b0, tx_busy}, 32'h0);
        wait_idle();
        compare_rx("rx55");

        // Back-to-back frames: one idle cycle between them
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        bus_write(BASE, 32'h41);
        bus_write(BASE, 32'h42);
        repeat (10 * CPB + 1) @(negedge clk);
        check("gap_idle", {31'b0, tx}, 32'h1);
        @(negedge clk);
        check("gap_start", {31'b0, tx}, 32'h0);
        wait_idle();
        compare_rx("rx4142");

        // Overflow scenario 0x01..0x06
        run_burst(6, 1'b0, 8'h01);

        // Random bursts, including overflowing lengths
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, DEPTH + 3);
            run_burst(n, 1'b1, 8'h00);
        end

        // Reset in the middle of data bit 3
        mon_en = 1'b0;
        bus_write(BASE, 32'hA5);
        repeat (2 + 4 * CPB) @(negedge clk);
        check("bit3_before_rst", {31'b0, tx}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("tx_after_rst", {31'b0, tx}, 32'h1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            check("post_rst_tx", {31'b0, tx}, 32'h1);
        end
        check("post_rst_busy", {31'b0, tx_busy}, 32'h0);
        read_status("post_rst_status", 32'h4);
        mon_en = 1'b1;

        // Unmapped addresses
        bus_write(BASE + 32'd8, 32'h55);
        iobus_addr = BASE + 32'd12;
        #1;
        check("unmapped_read", iobus_rd_data, 32'h0);
        iobus_addr = BASE;
        #1;
        check("txdata_read", iobus_rd_data, 32'h0);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check("unmapped_tx", {31'b0, tx}, 32'h1);
        end
        check("unmapped_busy", {31'b0, tx_busy}, 32'h0);
        compare_rx("unmapped_rx");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
